// File: rtl/vga_pixel_prefetch.sv
// Prefetch FIFO feeding RGB565 pixels to the VGA timing driver, resynchronised on every vsync fall.
// Optional colour-bar test pattern is compiled in with `define VGA_PATTERN_EN.
module vga_pixel_prefetch #(
    parameter int          DEPTH           = 64,
    parameter int          AW              = 6,
    parameter int          PREFILL         = 32,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic          vga_clk,
    input  logic          sys_rst,
    input  logic          vga_vs,
    input  logic          data_req,
    input  logic [9:0]    pixel_xpos,
    output logic [15:0]   pixel_data,
    input  logic [15:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          frame_start,
    output logic [AW:0]   fill_level,
    output logic          underflow,
    input  logic          err_clr
`ifdef VGA_PATTERN_EN
    ,
    input  logic          pattern_en
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [AW:0]   DEPTH_L   = DEPTH[AW:0];
    localparam logic [AW:0]   PREFILL_L = PREFILL[AW:0];
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    logic [15:0]   mem_r [DEPTH];
    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          vs_d_r;
    logic          frame_start_r;
    logic [15:0]   pixel_data_r;
    logic          underflow_r;
    logic          vs_fall_s;
    logic          push_s;
    logic          pop_s;
    logic          pat_sel_s;
    logic [15:0]   pixel_next_s;
    logic          uf_set_s;

`ifdef VGA_PATTERN_EN
    function automatic logic [15:0] bar_color(input logic [9:0] x);
        logic [15:0] c;
        if (x < 10'd80)       c = 16'hFFFF;
        else if (x < 10'd160) c = 16'hFFE0;
        else if (x < 10'd240) c = 16'h07FF;
        else if (x < 10'd320) c = 16'h07E0;
        else if (x < 10'd400) c = 16'hF81F;
        else if (x < 10'd480) c = 16'hF800;
        else if (x < 10'd560) c = 16'h001F;
        else                  c = 16'h0000;
        return c;
    endfunction

    assign pat_sel_s = pattern_en;
`else
    logic xpos_unused_s;
    assign xpos_unused_s = ^pixel_xpos;
    assign pat_sel_s     = 1'b0;
`endif

    assign vs_fall_s   = vs_d_r & ~vga_vs;
    assign s_ready     = ((state_r == ST_FILL) || (state_r == ST_RUN)) && (count_r < DEPTH_L);
    assign push_s      = s_valid & s_ready;
    assign pop_s       = data_req && (count_r != CNT_ZERO) && (state_r == ST_RUN);
    assign pixel_data  = pixel_data_r;
    assign frame_start = frame_start_r;
    assign fill_level  = count_r;
    assign underflow   = underflow_r;

    // Frame sequencing: a vsync fall always restarts the frame from FLUSH
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (vs_fall_s) state_next_s = ST_FLUSH;
                else           state_next_s = ST_IDLE;
            end
            ST_FLUSH: state_next_s = ST_FILL;
            ST_FILL: begin
                if (vs_fall_s)                 state_next_s = ST_FLUSH;
                else if (count_r >= PREFILL_L) state_next_s = ST_RUN;
                else                           state_next_s = ST_FILL;
            end
            ST_RUN: begin
                if (vs_fall_s) state_next_s = ST_FLUSH;
                else           state_next_s = ST_RUN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next pixel selection; a non-pop request in RUN can only mean the FIFO is empty
    always_comb begin
        pixel_next_s = 16'd0;
        uf_set_s     = 1'b0;
        if (!data_req) begin
            pixel_next_s = 16'd0;
            uf_set_s     = 1'b0;
        end else if (pat_sel_s) begin
`ifdef VGA_PATTERN_EN
            pixel_next_s = bar_color(pixel_xpos);
`else
            pixel_next_s = 16'd0;
`endif
            uf_set_s     = 1'b0;
        end else if (pop_s) begin
            pixel_next_s = mem_r[rd_ptr_r];
            uf_set_s     = 1'b0;
        end else begin
            pixel_next_s = UNDERFLOW_COLOR;
            uf_set_s     = (state_r == ST_RUN);
        end
    end

    // FSM, pointers and occupancy; entering FLUSH discards the previous frame's contents
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_r       <= ST_IDLE;
            vs_d_r        <= 1'b1;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            vs_d_r        <= vga_vs;
            frame_start_r <= (state_next_s == ST_FLUSH);
            if (state_next_s == ST_FLUSH) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
                count_r  <= CNT_ZERO;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Pixel storage
    always_ff @(posedge vga_clk) begin
        if (push_s) mem_r[wr_ptr_r] <= s_data;
    end

    // Registered pixel output and sticky underrun flag (set wins over clear)
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pixel_data_r <= 16'd0;
            underflow_r  <= 1'b0;
        end else begin
            pixel_data_r <= pixel_next_s;
            if (uf_set_s)     underflow_r <= 1'b1;
            else if (err_clr) underflow_r <= 1'b0;
            else              underflow_r <= underflow_r;
        end
    end

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Self-checking bench for vga_pixel_prefetch: queue-based frame model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_vga_pixel_prefetch;

    logic        vga_clk;
    logic        sys_rst;
    logic        vga_vs;
    logic        data_req;
    logic [9:0]  pixel_xpos;
    logic [15:0] pixel_data;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        frame_start;
    logic [6:0]  fill_level;
    logic        underflow;
    logic        err_clr;
    logic        pattern_en;

    vga_pixel_prefetch dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .vga_vs      (vga_vs),
        .data_req    (data_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_data  (pixel_data),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .frame_start (frame_start),
        .fill_level  (fill_level),
        .underflow   (underflow),
`ifdef VGA_PATTERN_EN
        .pattern_en  (pattern_en),
`endif
        .err_clr     (err_clr)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pixels held, whether the frame has been synced/primed/started, visible outputs
    logic [15:0] m_q[$];
    bit          m_flush, m_fill, m_run, m_vsd, m_uf, m_last_push;
    logic [15:0] m_pix;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [15:0] bar_of(input logic [9:0] x);
        int idx;
        idx = int'(x) / 80;
        if (idx > 7) idx = 7;
        return bars[idx];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_flush = 0; m_fill = 0; m_run = 0; m_vsd = 1; m_uf = 0;
        m_pix = 16'h0000; m_last_push = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; vga_vs = 1'b1; data_req = 1'b0; s_valid = 1'b0;
        s_data = 16'h0000; err_clr = 1'b0; pixel_xpos = 10'd0; pattern_en = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, compare all outputs with the model, then advance the model
    task automatic cycle(input logic vs, input logic req, input logic valid, input logic [15:0] d,
                         input logic clr, input logic [9:0] xpos, input logic pat);
        int sz;
        bit ready, push, pop, vsfall;
        vga_vs = vs; data_req = req; s_valid = valid; s_data = d; err_clr = clr;
        pixel_xpos = xpos; pattern_en = pat;
        #1;
        sz    = m_q.size();
        ready = (m_fill || m_run) && sz < 64;
        chk("s_ready", s_ready, ready);
        chk("fill_level", fill_level, sz);
        chk("frame_start", frame_start, m_flush);
        chk("pixel_data", pixel_data, m_pix);
        chk("underflow", underflow, m_uf);
        vsfall = m_vsd && !vs;
        push   = valid && ready;
        pop    = req && m_run && sz > 0;
        if (!req)     m_pix = 16'h0000;
        else if (pat) m_pix = bar_of(xpos);
        else if (pop) m_pix = m_q[0];
        else          m_pix = 16'hF800;
        if (req && !pat && m_run && sz == 0) m_uf = 1;
        else if (clr)                        m_uf = 0;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(d);
        m_last_push = push;
        if (vsfall && !m_flush) begin
            m_q.delete(); m_flush = 1; m_fill = 0; m_run = 0;
        end else if (m_flush) begin
            m_flush = 0; m_fill = 1;
        end else if (m_fill && sz >= 32) begin
            m_fill = 0; m_run = 1;
        end
        m_vsd = vs;
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] nd;
        int fs_cnt;
        int guard;

        do_reset();
        chk("lit_reset_pixel", pixel_data, 16'h0000);
        chk("lit_reset_fill", fill_level, 7'd0);

        // No vsync fall: nothing accepted
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 10'd0, 1'b0);
        chk("lit_idle_ready", s_ready, 1'b0);
        chk("lit_idle_fill", fill_level, 7'd0);

        // Sync, prefill, then a full 640-pixel line
        nd = 16'h0001;
        fs_cnt = 0;
        cycle(1'b0, 1'b0, 1'b1, nd, 1'b0, 10'd0, 1'b0);
        fs_cnt += int'(frame_start);
        chk("lit_sync_frame_start", frame_start, 1'b1);
        guard = 0;
        while (!m_run && guard < 200) begin
            cycle(1'b0, 1'b0, 1'b1, nd, 1'b0, 10'd0, 1'b0);
            fs_cnt += int'(frame_start);
            if (m_last_push) nd++;
            guard++;
        end
        chk("fill_to_run_in_bound", (guard < 200), 1'b1);
        chk("lit_frame_start_pulses", fs_cnt, 1);
        chk("lit_run_fill", fill_level, 7'd33);
        for (int i = 0; i < 640; i++) begin
            cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd0, 1'b0);
            if (m_last_push) nd++;
            if (i == 0) chk("lit_first_pixel", pixel_data, 16'h0001);
        end
        chk("lit_last_pixel", pixel_data, 16'h0280);
        chk("lit_no_underflow", underflow, 1'b0);

        // Stall upstream with 32 buffered, 40 requests
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 1'b0);
        chk("lit_32_buffered", fill_level, 7'd32);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 1'b0);
        chk("lit_underrun_color", pixel_data, 16'hF800);
        chk("lit_underflow_set", underflow, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 10'd0, 1'b0);
        chk("lit_set_beats_clear", underflow, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 1'b0);
        chk("lit_clear", underflow, 1'b0);

        // Saturate, then pop with a valid word while full
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, 1'b0, 1'b1, nd, 1'b0, 10'd0, 1'b0);
            if (m_last_push) nd++;
        end
        chk("lit_full_level", fill_level, 7'd64);
        chk("lit_full_ready", s_ready, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, nd, 1'b0, 10'd0, 1'b0);
        if (m_last_push) nd++;
        chk("lit_pop_when_full", fill_level, 7'd63);
        cycle(1'b1, 1'b0, 1'b1, nd, 1'b0, 10'd0, 1'b0);
        if (m_last_push) nd++;
        chk("lit_refill", fill_level, 7'd64);

        // Drain to 20, then vsync fall mid-RUN
        for (int i = 0; i < 44; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 1'b0);
        chk("lit_20_left", fill_level, 7'd20);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 1'b0);
        chk("lit_flush_frame_start", frame_start, 1'b1);
        chk("lit_flush_fill", fill_level, 7'd0);
        nd = 16'h1000;
        guard = 0;
        while (!m_run && guard < 200) begin
            cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd0, 1'b0);
            if (m_last_push) nd++;
            guard++;
        end
        chk("refill_in_bound", (guard < 200), 1'b1);
        chk("lit_fill_req_color", pixel_data, 16'hF800);
        cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd0, 1'b0);
        if (m_last_push) nd++;
        chk("lit_new_frame_head", pixel_data, 16'h1000);

`ifdef VGA_PATTERN_EN
        cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd0, 1'b1);
        if (m_last_push) nd++;
        chk("lit_bar_0", pixel_data, 16'hFFFF);
        cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd80, 1'b1);
        if (m_last_push) nd++;
        chk("lit_bar_80", pixel_data, 16'hFFE0);
        cycle(1'b0, 1'b1, 1'b1, nd, 1'b0, 10'd560, 1'b1);
        if (m_last_push) nd++;
        chk("lit_bar_560", pixel_data, 16'h0000);
`endif

        // Reset mid-frame: back to idle, requests answered with the underrun colour only
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 10'd0, 1'b0);
        chk("lit_post_reset_fill", fill_level, 7'd0);
        chk("lit_post_reset_pixel", pixel_data, 16'hF800);
        chk("lit_post_reset_uf", underflow, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
